// File: rtl/clk_div_monitor.sv
// clk_div_monitor: period / duty self-check of a divided clock, half-cycle resolution.
// Optional saturating error counter: define CLKMON_ERRCNT_EN.
module clk_div_monitor #(
  parameter int N        = 7,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 255,
  parameter int DUTY_TOL = 0
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       clk_meas,
  input  logic       enable,
  input  logic       err_clr,
  output logic [7:0] period,
  output logic [8:0] high_half,
  output logic       meas_valid,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    MEAS
  } state_t;

  localparam logic [7:0] NP  = 8'(N);
  localparam logic [8:0] NH  = 9'(N);
  localparam logic [7:0] TO  = 8'(TIMEOUT);
  localparam logic [8:0] TOL = 9'(DUTY_TOL);
  localparam logic [3:0] LC  = 4'(LOCK_CNT);

  state_t     state_q, state_d;
  logic       s_n_q, s_p_q, s_p_d_q;
  logic       rise;
  logic [7:0] cyc_q, cyc_d, cyc_inc;
  logic [8:0] acc_q, acc_d, acc_inc;
  logic [9:0] acc_sum;
  logic [8:0] diff, smp;
  logic [7:0] per_q, per_d;
  logic [8:0] hh_q, hh_d;
  logic       mv_q, mv_d;
  logic       lk_q, lk_d;
  logic       err_q, err_d;
  logic [3:0] run_q, run_d;
  logic       good, err_ev;

  // clk_meas high time is resolved by also sampling on the falling edge
  always_ff @(negedge clk_in or posedge reset) begin
    if (reset) s_n_q <= 1'b0;
    else       s_n_q <= clk_meas;
  end

  assign rise    = s_p_q & ~s_p_d_q;
  assign smp     = {8'd0, s_p_q} + {8'd0, s_n_q};
  assign cyc_inc = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;
  assign acc_sum = {1'b0, acc_q} + {1'b0, smp};
  assign acc_inc = acc_sum[9] ? 9'h1FF : acc_sum[8:0];
  assign diff    = (acc_q >= NH) ? acc_q - NH : NH - acc_q;
  assign good    = (cyc_q == NP) && (diff <= TOL);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    acc_d   = acc_q;
    per_d   = per_q;
    hh_d    = hh_q;
    mv_d    = 1'b0;
    lk_d    = lk_q;
    run_d   = run_q;
    err_ev  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cyc_d   = '0;
      acc_d   = '0;
      run_d   = '0;
      lk_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cyc_d   = '0;
          acc_d   = '0;
          run_d   = '0;
          lk_d    = 1'b0;
          state_d = SYNC;
        end
        SYNC: begin
          if (rise) begin
            cyc_d   = 8'd1;
            acc_d   = smp;
            state_d = MEAS;
          end else if (cyc_q >= TO) begin
            err_ev = 1'b1;
            lk_d   = 1'b0;
            run_d  = '0;
            cyc_d  = '0;
            acc_d  = '0;
          end else begin
            cyc_d = cyc_inc;
          end
        end
        MEAS: begin
          if (rise) begin
            per_d = cyc_q;
            hh_d  = acc_q;
            mv_d  = 1'b1;
            cyc_d = 8'd1;
            acc_d = smp;
            if (good) begin
              run_d = (run_q >= LC) ? LC : run_q + 4'd1;
              if (run_d == LC) lk_d = 1'b1;
            end else begin
              run_d  = '0;
              lk_d   = 1'b0;
              err_ev = 1'b1;
            end
          end else if (cyc_q >= TO) begin
            err_ev  = 1'b1;
            lk_d    = 1'b0;
            run_d   = '0;
            cyc_d   = '0;
            acc_d   = '0;
            state_d = SYNC;
          end else begin
            cyc_d = cyc_inc;
            acc_d = acc_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // a new error outranks a simultaneous clear
  assign err_d = err_ev | (err_q & ~err_clr);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_p_q   <= 1'b0;
      s_p_d_q <= 1'b0;
      cyc_q   <= '0;
      acc_q   <= '0;
      per_q   <= '0;
      hh_q    <= '0;
      mv_q    <= 1'b0;
      lk_q    <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      s_p_q   <= clk_meas;
      s_p_d_q <= s_p_q;
      cyc_q   <= cyc_d;
      acc_q   <= acc_d;
      per_q   <= per_d;
      hh_q    <= hh_d;
      mv_q    <= mv_d;
      lk_q    <= lk_d;
      err_q   <= err_d;
      run_q   <= run_d;
    end
  end

`ifdef CLKMON_ERRCNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (err_ev) begin
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end else if (err_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign period     = per_q;
  assign high_half  = hh_q;
  assign meas_valid = mv_q;
  assign locked     = lk_q;
  assign err        = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: randomized divided-clock patterns against a report-level model.
// Works with or without CLKMON_ERRCNT_EN.
module tb_clk_div_monitor;

`ifdef CLKMON_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       clk_meas = 1'b0;
  logic       enable = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] period, b_period;
  logic [8:0] high_half, b_high_half;
  logic       meas_valid, b_meas_valid;
  logic       locked, b_locked;
  logic       err, b_err;
  logic [7:0] err_cnt, b_err_cnt;

  int total = 0;
  int bad   = 0;

  clk_div_monitor #(.N(7), .LOCK_CNT(4), .TIMEOUT(255), .DUTY_TOL(0)) dut (
    .clk_in(clk_in), .reset(reset), .clk_meas(clk_meas),
    .enable(enable), .err_clr(err_clr),
    .period(period), .high_half(high_half), .meas_valid(meas_valid),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  clk_div_monitor #(.N(7), .LOCK_CNT(4), .TIMEOUT(255), .DUTY_TOL(1)) dut_tol (
    .clk_in(clk_in), .reset(reset), .clk_meas(clk_meas),
    .enable(enable), .err_clr(err_clr),
    .period(b_period), .high_half(b_high_half), .meas_valid(b_meas_valid),
    .locked(b_locked), .err(b_err), .err_cnt(b_err_cnt)
  );

  always #5 clk_in = ~clk_in;

  // half-cycle pattern generator: hi_h high half-cycles then lo_h low
  int hi_h = 7;
  int lo_h = 7;
  int ph = 0;
  int rises = 0;
  bit gen_on = 1'b0;

  always @(clk_in) begin
    #1;
    if (gen_on) begin
      if (ph < hi_h && !clk_meas) rises++;
      clk_meas = (ph < hi_h);
      ph = (ph + 1) % (hi_h + lo_h);
    end else begin
      clk_meas = 1'b0;
      ph = 0;
    end
  end

  function automatic int exp_cnt(input int n);
    if (!CNT_EN) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic stop_run();
    enable = 1'b0;
    gen_on = 1'b0;
    repeat (3) @(posedge clk_in);
    #2;
  endtask

  task automatic start_run(input int hi, input int lo);
    hi_h = hi;
    lo_h = lo;
    err_clr = 1'b1;
    @(posedge clk_in);
    #2;
    err_clr = 1'b0;
    enable = 1'b1;
    gen_on = 1'b1;
  endtask

  task automatic wait_mv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_in);
      #2;
      if (meas_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_in);
    #2;
    total++;
    if (period !== 8'd0) begin
      bad++; $display("FAIL rst_period got=%0d exp=0", period);
    end
    total++;
    if (high_half !== 9'd0) begin
      bad++; $display("FAIL rst_high got=%0d exp=0", high_half);
    end
    total++;
    if ({meas_valid, locked, err} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b exp=000", {meas_valid, locked, err});
    end
    total++;
    if (err_cnt !== 8'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d exp=0", err_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_patterns();
    int hs[8];
    int ls[8];
    bit ok;
    hs[0] = 7; ls[0] = 7;
    hs[1] = 8; ls[1] = 8;
    hs[2] = 8; ls[2] = 6;
    for (int k = 3; k < 8; k++) begin
      int p;
      p = int'($urandom_range(6, 8));
      hs[k] = p - 1 + int'($urandom_range(0, 2));
      ls[k] = 2 * p - hs[k];
    end
    for (int k = 0; k < 8; k++) begin
      int p, run, nbad;
      bit g;
      p = (hs[k] + ls[k]) / 2;
      g = (p == 7) && (hs[k] == 7);
      run = 0;
      nbad = 0;
      stop_run();
      start_run(hs[k], ls[k]);
      for (int r = 0; r < 6; r++) begin
        wait_mv(ok);
        total++;
        if (!ok) begin
          bad++; $display("FAIL pat%0d_mv_timeout got=0 exp=1", k);
          break;
        end
        if (g) run++;
        else begin run = 0; nbad++; end
        total++;
        if (period !== 8'(p)) begin
          bad++; $display("FAIL pat%0d_period got=%0d exp=%0d", k, period, p);
        end
        total++;
        if (high_half !== 9'(hs[k])) begin
          bad++; $display("FAIL pat%0d_high got=%0d exp=%0d", k, high_half, hs[k]);
        end
        total++;
        if (locked !== (run >= 4)) begin
          bad++; $display("FAIL pat%0d_locked r=%0d got=%b exp=%b", k, r, locked, run >= 4);
        end
        total++;
        if (err !== (nbad > 0)) begin
          bad++; $display("FAIL pat%0d_err got=%b exp=%b", k, err, nbad > 0);
        end
        total++;
        if (err_cnt !== 8'(exp_cnt(nbad))) begin
          bad++; $display("FAIL pat%0d_cnt got=%0d exp=%0d", k, err_cnt, exp_cnt(nbad));
        end
      end
    end
  endtask

  task automatic test_duty_tol();
    bit ok;
    stop_run();
    start_run(8, 6);
    for (int r = 0; r < 5; r++) begin
      wait_mv(ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL tol_mv_timeout got=0 exp=1");
        break;
      end
      total++;
      if (b_locked !== (r >= 3)) begin
        bad++; $display("FAIL tol_locked r=%0d got=%b exp=%b", r, b_locked, r >= 3);
      end
      total++;
      if (b_err !== 1'b0 || err !== 1'b1) begin
        bad++; $display("FAIL tol_err got=%b%b exp=01", b_err, err);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int mv_seen;
    stop_run();
    start_run(7, 7);
    for (int r = 0; r < 5; r++) wait_mv(ok);
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL to_prelock got=%b exp=1", locked);
    end
    gen_on = 1'b0;
    mv_seen = 0;
    for (int i = 0; i < 280; i++) begin
      @(posedge clk_in);
      #2;
      if (meas_valid) mv_seen++;
    end
    total++;
    if (err !== 1'b1 || locked !== 1'b0 || mv_seen != 0) begin
      bad++;
      $display("FAIL to_flags got=err%b lk%b mv%0d exp=err1 lk0 mv0", err, locked, mv_seen);
    end
    total++;
    if (err_cnt !== 8'(exp_cnt(1))) begin
      bad++; $display("FAIL to_cnt got=%0d exp=%0d", err_cnt, exp_cnt(1));
    end
    gen_on = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_mv(ok);
      total++;
      if (!ok || period !== 8'd7 || locked !== (r == 3)) begin
        bad++;
        $display("FAIL to_relock r=%0d got=p%0d lk%b exp=p7 lk%b", r, period, locked, r == 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int r0;
    stop_run();
    start_run(7, 7);
    for (int r = 0; r < 5; r++) wait_mv(ok);
    @(posedge clk_in);
    #3;
    reset = 1'b1;
    #1;
    total++;
    if ({period, high_half, meas_valid, locked, err, err_cnt} !== '0) begin
      bad++;
      $display("FAIL mid_reset got=p%0d h%0d lk%b exp=all0", period, high_half, locked);
    end
    gen_on = 1'b0;
    repeat (2) @(posedge clk_in);
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clk_in);
    #2;
    r0 = rises;
    gen_on = 1'b1;
    wait_mv(ok);
    total++;
    if (!ok || rises - r0 != 2 || period !== 8'd7) begin
      bad++;
      $display("FAIL mid_restart got=rises%0d p%0d exp=rises2 p7", rises - r0, period);
    end
  endtask

  task automatic test_err_sat();
    bit ok;
    int miss;
    stop_run();
    start_run(6, 6);
    miss = 0;
    for (int r = 0; r < 300; r++) begin
      wait_mv(ok);
      if (!ok) miss++;
    end
    total++;
    if (miss != 0 || err_cnt !== 8'(exp_cnt(300))) begin
      bad++; $display("FAIL sat_cnt got=%0d miss=%0d exp=%0d", err_cnt, miss, exp_cnt(300));
    end
    repeat (5) @(posedge clk_in);
    #2;
    err_clr = 1'b1;
    @(posedge clk_in);
    #2;
    total++;
    if (meas_valid !== 1'b1 || err !== 1'b1 || err_cnt !== 8'(exp_cnt(301))) begin
      bad++;
      $display("FAIL sat_clr_race got=mv%b e%b c%0d exp=mv1 e1 c%0d",
               meas_valid, err, err_cnt, exp_cnt(301));
    end
    @(posedge clk_in);
    #2;
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL sat_clr got=e%b c%0d exp=e0 c0", err, err_cnt);
    end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_duty_tol();
    test_timeout();
    test_reset_mid();
    test_err_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
